// File: rtl/cipher_io_pkg.sv
// Shared types and constants for the ciphertext UART drain.
package cipher_io_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_t;

    // Bit positions inside the status byte read back by the processor.
    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_FULL = 1;
    localparam int unsigned STATUS_OVF  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO still lands when the same edge frees a slot.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cipher_uart_tx.sv
// Port-mapped ciphertext drain: PicoBlaze writes -> FIFO -> 8N1 UART, LSB first.
module cipher_uart_tx
    import cipher_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned DATA_PORT_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] status,
    output logic       tx
);

    localparam int unsigned    CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    uart_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;

    logic       push_req;
    logic       pop;
    logic       cnt_last;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       unused_port_id;

    // Only one port_id bit is decoded; the rest belong to other peripherals.
    assign unused_port_id = ^port_id;
    assign push_req       = write_strobe & port_id[DATA_PORT_BIT];
    assign cnt_last       = (cnt_q == CntLast);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (out_port),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow: a push was dropped because no slot was free or freed.
    assign ovf_d = ovf_q | (push_req & fifo_full & ~pop);

    // UART FSM next-state, bit timing and registered tx value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit to keep frames contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // tx follows the state being entered so the line is registered with no extra lag.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status byte assembled from registered sources only.
    always_comb begin
        status              = 8'h00;
        status[STATUS_BUSY] = (state_q != StIdle);
        status[STATUS_FULL] = fifo_full;
        status[STATUS_OVF]  = ovf_q;
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Directed bench for cipher_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_cipher_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] status;
    logic       tx;

    int total;
    int bad;

    cipher_uart_tx #(
        .CLKS_PER_BIT  (4),
        .FIFO_DEPTH    (4),
        .DATA_PORT_BIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .status       (status),
        .tx           (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a start bit, then mid-bit sampling; returns at the stop-bit midpoint.
    // waited is the cycle count until tx was seen low (-1 on timeout).
    task automatic capture_frame(output logic [7:0] data, output logic stop_bit,
                                 output int waited);
        waited   = 0;
        data     = 8'hxx;
        stop_bit = 1'bx;
        while (tx !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        if (tx !== 1'b0) begin
            waited = -1;
            return;
        end
        repeat (2) tick();
        for (int i = 0; i < 8; i++) begin
            repeat (4) tick();
            data[i] = tx;
        end
        repeat (4) tick();
        stop_bit = tx;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        reset = 1'b0;
        tick();
        total++;
        if (status !== 8'h00) begin
            bad++;
            $display("FAIL reset_status: got %h want 00", status);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic       s;
        int         w;
        write_strobe = 1'b1;
        port_id      = 8'h10;
        out_port     = 8'hA5;
        tick();
        write_strobe = 1'b0;
        total++;
        if (tx !== 1'b1 || status !== 8'h00) begin
            bad++;
            $display("FAIL single_edge_k: tx=%b status=%h want tx=1 status=00", tx, status);
        end
        tick();
        total++;
        if (tx !== 1'b0 || status !== 8'h01) begin
            bad++;
            $display("FAIL single_start: tx=%b status=%h want tx=0 status=01", tx, status);
        end
        capture_frame(d, s, w);
        total++;
        if (w !== 0 || d !== 8'hA5 || s !== 1'b1) begin
            bad++;
            $display("FAIL single_frame: data=%h stop=%b wait=%0d want A5 1 0", d, s, w);
        end
        tick();
        total++;
        if (status !== 8'h01 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_last_stop: status=%h tx=%b want 01 1", status, tx);
        end
        tick();
        total++;
        if (status !== 8'h00 || tx !== 1'b1) begin
            bad++;
            $display("FAIL single_idle: status=%h tx=%b want 00 1", status, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       s;
        int         w;
        port_id      = 8'h10;
        write_strobe = 1'b1;
        out_port     = 8'h00;
        tick();
        out_port     = 8'hFF;
        tick();
        write_strobe = 1'b0;
        capture_frame(d, s, w);
        total++;
        if (w !== 0 || d !== 8'h00 || s !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: data=%h stop=%b wait=%0d want 00 1 0", d, s, w);
        end
        capture_frame(d, s, w);
        total++;
        if (w !== 2 || d !== 8'hFF || s !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: data=%h stop=%b wait=%0d want FF 1 2", d, s, w);
        end
        repeat (2) tick();
        total++;
        if (status !== 8'h00) begin
            bad++;
            $display("FAIL b2b_idle: status=%h want 00", status);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       s;
        int         w;
        fork
            begin
                port_id = 8'h10;
                for (int i = 0; i < 6; i++) begin
                    write_strobe = 1'b1;
                    out_port     = 8'(i + 1);
                    tick();
                    if (i == 4) begin
                        total++;
                        if (status !== 8'h03) begin
                            bad++;
                            $display("FAIL ovf_full: status=%h want 03", status);
                        end
                    end
                end
                write_strobe = 1'b0;
                total++;
                if (status !== 8'h07) begin
                    bad++;
                    $display("FAIL ovf_set: status=%h want 07", status);
                end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    capture_frame(d, s, w);
                    total++;
                    if (w !== 2 || d !== 8'(i + 1) || s !== 1'b1) begin
                        bad++;
                        $display("FAIL ovf_frame%0d: data=%h stop=%b wait=%0d want %h 1 2",
                                 i, d, s, w, 8'(i + 1));
                    end
                end
            end
        join
        repeat (12) tick();
        total++;
        if (status !== 8'h04 || tx !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: status=%h tx=%b want 04 1", status, tx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (status !== 8'h00) begin
            bad++;
            $display("FAIL ovf_clear: status=%h want 00", status);
        end
    endtask

    task automatic test_full_concurrent_pop();
        logic [7:0] d;
        logic [7:0] exp_bytes [6];
        logic       s;
        int         w;
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            begin
                port_id = 8'h10;
                for (int i = 0; i < 5; i++) begin
                    write_strobe = 1'b1;
                    out_port     = exp_bytes[i];
                    tick();
                end
                write_strobe = 1'b0;
                repeat (36) tick();
                total++;
                if (status !== 8'h03) begin
                    bad++;
                    $display("FAIL pop_pre: status=%h want 03", status);
                end
                write_strobe = 1'b1;
                out_port     = exp_bytes[5];
                tick();
                write_strobe = 1'b0;
                total++;
                if (status !== 8'h03) begin
                    bad++;
                    $display("FAIL pop_post: status=%h want 03", status);
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    capture_frame(d, s, w);
                    total++;
                    if (w !== 2 || d !== exp_bytes[i] || s !== 1'b1) begin
                        bad++;
                        $display("FAIL pop_frame%0d: data=%h stop=%b wait=%0d want %h 1 2",
                                 i, d, s, w, exp_bytes[i]);
                    end
                end
            end
        join
        repeat (2) tick();
        total++;
        if (status !== 8'h00) begin
            bad++;
            $display("FAIL pop_idle: status=%h want 00", status);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        int busy_cnt;
        port_id      = 8'h10;
        write_strobe = 1'b1;
        out_port     = 8'h3C;
        tick();
        out_port     = 8'h81;
        tick();
        out_port     = 8'h7E;
        tick();
        write_strobe = 1'b0;
        // One cycle into the frame; step to the first cycle of data bit 3.
        repeat (15) tick();
        total++;
        if (status !== 8'h01 || tx !== 1'b1) begin
            bad++;
            $display("FAIL mid_before: status=%h tx=%b want 01 1", status, tx);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (status !== 8'h00 || tx !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: status=%h tx=%b want 00 1", status, tx);
        end
        lows     = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (status !== 8'h00) busy_cnt++;
        end
        total++;
        if (lows !== 0 || busy_cnt !== 0) begin
            bad++;
            $display("FAIL mid_quiet: tx_low_cycles=%0d nonzero_status=%0d want 0 0",
                     lows, busy_cnt);
        end
    endtask

    task automatic test_decode();
        int lows;
        port_id      = 8'h08;
        out_port     = 8'h55;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'h00;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL decode_tx: tx_low_cycles=%0d want 0", lows);
        end
        total++;
        if (status !== 8'h00) begin
            bad++;
            $display("FAIL decode_status: status=%h want 00", status);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_concurrent_pop();
        test_reset_mid_frame();
        test_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
